goertzel_bank: RTL

- Time-multiplexed multi-bin Goertzel detector. One sample stream is shared across NUM_BINS tone bins through a single multiplier datapath.
- Accumulates exactly BLOCK_LEN samples per block, then emits one power value per bin (|X_k|^2) and resets its filter state for the next block.
- Sits after the sample decimator and feeds the tone-detect/threshold logic. It is the block-based, multi-channel successor to the single-bin streaming Goertzel stage.

---
 rtl/goertzel_pkg.sv | 27 ++
 rtl/goertzel_bank_if.sv | 30 +++
 rtl/goertzel_bin_mac.sv | 30 +++
 rtl/goertzel_bank.sv | 115 +++++++++++
 4 files changed

// File: rtl/goertzel_pkg.sv
// Shared types and fixed-point helpers for the multi-bin Goertzel detector.
// Helpers work at fixed wide widths; callers size-cast the results back down.
package goertzel_pkg;

  typedef enum logic [1:0] {IDLE, UPDATE, POWER} state_e;
  typedef enum logic {MAC_UPDATE, MAC_POWER} mac_mode_e;

  // Wide enough for STATE_W+COEFF_W products and 2*STATE_W+COEFF_W power terms
  localparam int MQ_W = 64;
  localparam int P_W  = 128;

  function automatic logic signed [MQ_W-1:0] mult_q(input logic signed [MQ_W-1:0] a,
                                                     input logic signed [MQ_W-1:0] coeff,
                                                     input int frac);
    return (a * coeff) >>> frac;
  endfunction

  function automatic logic [P_W-1:0] sat_pwr(input logic signed [P_W-1:0] p,
                                             input int out_w);
    logic [P_W-1:0] mag;
    mag = p;
    if (p < 0) return '0;
    if ((mag >> out_w) != '0) return {P_W{1'b1}} >> (P_W - out_w);
    return mag;
  endfunction

endpackage

// File: rtl/goertzel_bank_if.sv
// Sample-in / power-out bundle of the Goertzel bank; master is the source and consumer side.
// Input is valid/ready; the power output is a strobe with no backpressure.
interface goertzel_bank_if #(
  parameter int NUM_BINS = 4,
  parameter int DATA_W   = 16,
  parameter int STATE_W  = 32,
  parameter int COEFF_W  = 18
);
  localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;

  logic                         clr;
  logic [NUM_BINS*COEFF_W-1:0]  coeff_i;
  logic signed [DATA_W-1:0]     data_i;
  logic                         valid_i;
  logic                         ready_o;
  logic                         pwr_valid_o;
  logic [BIN_W-1:0]             pwr_bin_o;
  logic [2*STATE_W-1:0]         pwr_o;
  logic                         block_done_o;

  modport master (
    output clr, coeff_i, data_i, valid_i,
    input  ready_o, pwr_valid_o, pwr_bin_o, pwr_o, block_done_o
  );

  modport slave (
    input  clr, coeff_i, data_i, valid_i,
    output ready_o, pwr_valid_o, pwr_bin_o, pwr_o, block_done_o
  );
endinterface

// File: rtl/goertzel_bin_mac.sv
// Combinational per-bin datapath: filter update (s0) or clamped, saturated power.
// Zero latency, no handshake; the caller sequences bins.
module goertzel_bin_mac
  import goertzel_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int STATE_W    = 32,
  parameter int COEFF_W    = 18,
  parameter int COEFF_FRAC = 14
) (
  input  logic signed [DATA_W-1:0]  x,
  input  logic signed [STATE_W-1:0] s1,
  input  logic signed [STATE_W-1:0] s2,
  input  logic signed [COEFF_W-1:0] coeff,
  input  mac_mode_e                 mode,
  output logic [2*STATE_W-1:0]      res
);
  localparam int RES_W = 2*STATE_W;

  logic signed [MQ_W-1:0]    q;
  logic signed [STATE_W-1:0] s0;
  logic signed [P_W-1:0]     p;

  assign q  = mult_q(MQ_W'(s1), MQ_W'(coeff), COEFF_FRAC);
  // Filter state wraps at STATE_W by design
  assign s0 = STATE_W'(MQ_W'(x) + q - MQ_W'(s2));
  assign p  = P_W'(s1) * P_W'(s1) + P_W'(s2) * P_W'(s2) - P_W'(q) * P_W'(s2);

  assign res = (mode == MAC_POWER) ? RES_W'(sat_pwr(p, RES_W)) : RES_W'(s0);
endmodule

// File: rtl/goertzel_bank.sv
// Time-multiplexed Goertzel bank: NUM_BINS update cycles per sample, NUM_BINS power cycles per block.
// ready drops for NUM_BINS cycles per sample (2*NUM_BINS on the last); power strobes have no backpressure.
module goertzel_bank
  import goertzel_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int STATE_W    = 32,
  parameter int COEFF_W    = 18,
  parameter int COEFF_FRAC = 14,
  parameter int NUM_BINS   = 4,
  parameter int BLOCK_LEN  = 256
) (
  input logic             clk,
  input logic             rst,
  goertzel_bank_if.slave  bus
);
  localparam int BIN_W = (NUM_BINS > 1) ? $clog2(NUM_BINS) : 1;
  localparam int CNT_W = $clog2(BLOCK_LEN);
  localparam logic [BIN_W-1:0] BIN_LAST = BIN_W'(NUM_BINS - 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLOCK_LEN - 1);

  state_e                    state_q, state_d;
  logic [BIN_W-1:0]          bin_q;
  logic [CNT_W-1:0]          cnt_q;
  logic signed [DATA_W-1:0]  x_q;
  logic signed [STATE_W-1:0] s1_q [NUM_BINS];
  logic signed [STATE_W-1:0] s2_q [NUM_BINS];
  logic signed [COEFF_W-1:0] coeff_sel;
  mac_mode_e                 mode;
  logic [2*STATE_W-1:0]      mac_res;
  logic                      last_bin, last_sample;

  assign last_bin    = (bin_q == BIN_LAST);
  assign last_sample = (cnt_q == CNT_LAST);

  always_comb begin
    coeff_sel = '0;
    for (int k = 0; k < NUM_BINS; k++)
      if (bin_q == BIN_W'(k)) coeff_sel = bus.coeff_i[k*COEFF_W +: COEFF_W];
  end

  goertzel_bin_mac #(
    .DATA_W(DATA_W), .STATE_W(STATE_W), .COEFF_W(COEFF_W), .COEFF_FRAC(COEFF_FRAC)
  ) u_mac (
    .x(x_q), .s1(s1_q[bin_q]), .s2(s2_q[bin_q]), .coeff(coeff_sel), .mode(mode), .res(mac_res)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    mode        = MAC_UPDATE;
    bus.ready_o = 1'b0;
    case (state_q)
      IDLE: begin
        bus.ready_o = 1'b1;
        if (bus.valid_i) state_d = UPDATE;
      end
      UPDATE: if (last_bin) state_d = last_sample ? POWER : IDLE;
      POWER: begin
        mode = MAC_POWER;
        if (last_bin) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // clr wins over a same-cycle accept: the sample is dropped
    if (bus.clr) state_d = IDLE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bin_q <= '0; cnt_q <= '0; x_q <= '0;
      for (int k = 0; k < NUM_BINS; k++) begin
        s1_q[k] <= '0; s2_q[k] <= '0;
      end
      bus.pwr_valid_o <= 1'b0; bus.block_done_o <= 1'b0;
      bus.pwr_bin_o <= '0; bus.pwr_o <= '0;
    end else if (bus.clr) begin
      bin_q <= '0; cnt_q <= '0; x_q <= '0;
      for (int k = 0; k < NUM_BINS; k++) begin
        s1_q[k] <= '0; s2_q[k] <= '0;
      end
      bus.pwr_valid_o <= 1'b0; bus.block_done_o <= 1'b0;
      bus.pwr_bin_o <= '0; bus.pwr_o <= '0;
    end else begin
      bus.pwr_valid_o  <= 1'b0;
      bus.block_done_o <= 1'b0;
      case (state_q)
        IDLE: if (bus.valid_i) begin
          x_q   <= bus.data_i;
          bin_q <= '0;
        end
        UPDATE: begin
          s1_q[bin_q] <= mac_res[STATE_W-1:0];
          s2_q[bin_q] <= s1_q[bin_q];
          bin_q       <= last_bin ? '0 : bin_q + 1'b1;
          if (last_bin) cnt_q <= last_sample ? '0 : cnt_q + 1'b1;
        end
        POWER: begin
          bus.pwr_o        <= mac_res;
          bus.pwr_valid_o  <= 1'b1;
          bus.pwr_bin_o    <= bin_q;
          bus.block_done_o <= last_bin;
          s1_q[bin_q]      <= '0;
          s2_q[bin_q]      <= '0;
          bin_q            <= last_bin ? '0 : bin_q + 1'b1;
        end
        default: ;
      endcase
    end
  end
endmodule
